// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_pkg
// Description : Shared frame format definitions: parser states, header field
//               positions, default sync marker and a header view struct.
// Revision    : 1.0  initial release
// ============================================================================
package frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;

    localparam int MARK_HI = 31;
    localparam int MARK_LO = 24;
    localparam int ID_HI   = 23;
    localparam int ID_LO   = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;

    localparam logic [7:0] SYNC_MARK_DEFAULT = 8'hA5;

    // Field order matches the bit positions above
    typedef struct packed {
        logic [7:0]  mark;
        logic [7:0]  id;
        logic [15:0] len;
    } header_t;

    function automatic header_t unpack_header(input logic [31:0] word);
        return header_t'(word);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_unpacker_skid.sv
`default_nettype none
// ============================================================================
// Module      : frame_unpacker_skid
// Description : Two-entry input buffer in front of the parser. Issues FIFO
//               reads, tracks the one read in flight and presents the oldest
//               word as a head with a pop strobe.
// Revision    : 1.0  initial release
// ============================================================================
module frame_unpacker_skid
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        head_valid_o,
    output logic [31:0] head_data_o,
    input  logic        head_pop_i
);

    logic [31:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic        inflight_q;
    logic        w_push;
    logic        w_pop;

    // A read is only issued when its returning word is guaranteed a free slot
    assign fifo_rd_en   = !rst && !fifo_empty &&
                          (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
    assign w_push       = inflight_q;
    assign w_pop        = head_pop_i && (count_q != 2'd0);
    assign head_valid_o = (count_q != 2'd0);
    assign head_data_o  = mem_q[rd_ptr_q];

    // Buffer storage, pointers, occupancy and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (w_push) begin
                mem_q[wr_ptr_q] <= fifo_rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : frame_unpacker
// Description : Drains formatted frame words from a FIFO read port, checks
//               header marker, length and XOR trailer, and re-emits payload
//               as a valid/ready stream with SOP/EOP/error sideband and
//               saturating statistics counters.
// Revision    : 1.0  initial release
// ============================================================================
module frame_unpacker
    import frame_pkg::*;
#(
    parameter int         MAX_LEN   = 256,
    parameter logic [7:0] SYNC_MARK = SYNC_MARK_DEFAULT,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_rd_data,
    input  logic             fifo_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_err,
    output logic [7:0]       out_frame_id,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    localparam logic [16:0] C_MAX_LEN = 17'(MAX_LEN);

    state_t           state_q;
    logic [15:0]      remaining_q;
    logic [31:0]      acc_q;
    logic [31:0]      hold_q;
    logic [7:0]       id_q;
    logic             first_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic             out_sop_q;
    logic             out_eop_q;
    logic             out_err_q;
    logic [7:0]       out_frame_id_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             w_head_valid;
    logic [31:0]      w_head_data;
    logic             w_pop;
    logic             w_slot_free;
    logic             w_len_ok;
    logic             w_bad_sum;
    header_t          w_hdr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    frame_unpacker_skid u_skid (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .head_valid_o (w_head_valid),
        .head_data_o  (w_head_data),
        .head_pop_i   (w_pop)
    );

    assign w_hdr       = unpack_header(w_head_data);
    assign w_slot_free = !out_valid_q || out_ready;
    assign w_len_ok    = (w_hdr.len != 16'd0) && ({1'b0, w_hdr.len} <= C_MAX_LEN);
    assign w_bad_sum   = (w_head_data != acc_q);

    // Head consumption: headers always, the last payload word into the hold
    // register always, everything that produces a beat only into a free slot
    always_comb begin
        w_pop = 1'b0;
        case (state_q)
            HUNT:    w_pop = w_head_valid;
            PAYLOAD: w_pop = w_head_valid && ((remaining_q == 16'd1) || w_slot_free);
            TRAILER: w_pop = w_head_valid && w_slot_free;
            default: w_pop = 1'b0;
        endcase
    end

    // Parser state machine with registered output beat and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            remaining_q    <= 16'd0;
            acc_q          <= 32'd0;
            hold_q         <= 32'd0;
            id_q           <= 8'd0;
            first_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 32'd0;
            out_sop_q      <= 1'b0;
            out_eop_q      <= 1'b0;
            out_err_q      <= 1'b0;
            out_frame_id_q <= 8'd0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
            drop_cnt_q     <= '0;
        end else begin
            if (w_slot_free) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                HUNT: begin
                    if (w_pop) begin
                        if (w_hdr.mark != SYNC_MARK) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end else if (!w_len_ok) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end else begin
                            id_q        <= w_hdr.id;
                            remaining_q <= w_hdr.len;
                            acc_q       <= 32'd0;
                            first_q     <= 1'b1;
                            state_q     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pop) begin
                        acc_q <= acc_q ^ w_head_data;
                        if (remaining_q == 16'd1) begin
                            // Held back so EOP can carry the trailer verdict
                            hold_q  <= w_head_data;
                            state_q <= TRAILER;
                        end else begin
                            out_valid_q    <= 1'b1;
                            out_data_q     <= w_head_data;
                            out_sop_q      <= first_q;
                            out_eop_q      <= 1'b0;
                            out_err_q      <= 1'b0;
                            out_frame_id_q <= id_q;
                            first_q        <= 1'b0;
                            remaining_q    <= remaining_q - 16'd1;
                        end
                    end
                end
                TRAILER: begin
                    if (w_pop) begin
                        out_valid_q    <= 1'b1;
                        out_data_q     <= hold_q;
                        out_sop_q      <= first_q;
                        out_eop_q      <= 1'b1;
                        out_err_q      <= w_bad_sum;
                        out_frame_id_q <= id_q;
                        frame_cnt_q    <= sat_inc(frame_cnt_q);
                        if (w_bad_sum) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                        end
                        state_q <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign out_err      = out_err_q;
    assign out_frame_id = out_frame_id_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign busy         = (state_q != HUNT);

endmodule
`default_nettype wire

// File: tb/tb_frame_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_unpacker
// Description : Directed bench for frame_unpacker: FIFO model, beat capture,
//               table of frames plus backpressure, reset and saturation runs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frame_unpacker;

    localparam int CNT_W   = 3;
    localparam int MAX_LEN = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_rd_en;
    logic [31:0]      fifo_rd_data = 32'd0;
    logic             fifo_empty;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_sop;
    logic             out_eop;
    logic             out_err;
    logic [7:0]       out_frame_id;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             busy;

    always #5 clk = ~clk;

    frame_unpacker #(
        .MAX_LEN   (MAX_LEN),
        .SYNC_MARK (8'hA5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_err      (out_err),
        .out_frame_id (out_frame_id),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    // FIFO model: data returns one cycle after the read strobe
    logic [31:0] fmem [0:4095];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rd_empty_viol = 0;
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) begin
                rd_empty_viol = rd_empty_viol + 1;
            end else begin
                fifo_rd_data <= fmem[rd_cnt];
                rd_cnt       <= rd_cnt + 1;
            end
        end
    end

    // Beat capture and stall/skid monitors, sampled on the falling edge
    logic [31:0] b_data [0:255];
    logic [10:0] b_side [0:255];
    int          beat_n      = 0;
    int          stall_viol  = 0;
    int          stall_seen  = 0;
    int          full_viol   = 0;
    logic        prev_stall  = 1'b0;
    logic [42:0] prev_beat   = '0;

    always @(negedge clk) begin
        if (out_valid && out_ready && !rst) begin
            b_data[beat_n] = out_data;
            b_side[beat_n] = {out_sop, out_eop, out_err, out_frame_id};
            beat_n = beat_n + 1;
        end
        if (fifo_rd_en && (dut.u_skid.count_q == 2'd2)) begin
            full_viol = full_viol + 1;
        end
        if (prev_stall && !rst) begin
            if (!out_valid || ({out_data, out_sop, out_eop, out_err, out_frame_id} != prev_beat)) begin
                stall_viol = stall_viol + 1;
            end
        end
        prev_stall = out_valid && !out_ready && !rst;
        if (prev_stall) begin
            stall_seen = stall_seen + 1;
        end
        prev_beat = {out_data, out_sop, out_eop, out_err, out_frame_id};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wr_cnt] = w;
        wr_cnt = wr_cnt + 1;
    endtask

    // Waits for FIFO drained and parser quiet for several cycles
    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        for (int c = 0; c < 600 && quiet < 4; c++) begin
            @(posedge clk);
            #1;
            if (fifo_empty && !busy && !out_valid && !fifo_rd_en) quiet = quiet + 1;
            else quiet = 0;
        end
        chk({name, "_idle"}, 32'(quiet >= 4), 32'd1);
    endtask

    typedef struct {
        int          garbage;
        logic [7:0]  id;
        logic [15:0] len;
        int          npay;
        logic [3:0][31:0] pay;
        logic [31:0] trailer;
        int          exp_beats;
        logic        exp_err;
        logic [2:0]  exp_frames;
        logic [2:0]  exp_errs;
        logic [2:0]  exp_drops;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [31:0] x;
        logic [31:0] w;

        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_cnts", {23'd0, frame_cnt, err_cnt, drop_cnt}, 32'd0);
        rst = 1'b0;

        vecs[0] = '{garbage:0, id:8'h07, len:16'd3, npay:3,
                    pay:{32'h0, 32'h33, 32'h22, 32'h11}, trailer:32'h0,
                    exp_beats:3, exp_err:1'b0, exp_frames:3'd1, exp_errs:3'd0, exp_drops:3'd0};
        vecs[1] = '{garbage:0, id:8'h01, len:16'd1, npay:1,
                    pay:{32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, trailer:32'hDEADBEEF,
                    exp_beats:1, exp_err:1'b0, exp_frames:3'd2, exp_errs:3'd0, exp_drops:3'd0};
        vecs[2] = '{garbage:0, id:8'h01, len:16'd1, npay:1,
                    pay:{32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, trailer:32'h0,
                    exp_beats:1, exp_err:1'b1, exp_frames:3'd3, exp_errs:3'd1, exp_drops:3'd0};
        vecs[3] = '{garbage:3, id:8'h42, len:16'd2, npay:2,
                    pay:{32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678}, trailer:32'h88888888,
                    exp_beats:2, exp_err:1'b0, exp_frames:3'd4, exp_errs:3'd1, exp_drops:3'd3};
        vecs[4] = '{garbage:0, id:8'h09, len:16'd0, npay:0,
                    pay:'0, trailer:32'h0,
                    exp_beats:0, exp_err:1'b0, exp_frames:3'd4, exp_errs:3'd2, exp_drops:3'd3};
        vecs[5] = '{garbage:0, id:8'h0A, len:16'd9, npay:0,
                    pay:'0, trailer:32'h0,
                    exp_beats:0, exp_err:1'b0, exp_frames:3'd4, exp_errs:3'd3, exp_drops:3'd3};

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v    = vecs[i];
            base = beat_n;
            for (int g = 0; g < v.garbage; g++) push(32'h00AB_0000 | 32'(g));
            push({8'hA5, v.id, v.len});
            for (int p = 0; p < v.npay; p++) push(v.pay[p]);
            if (v.npay > 0) push(v.trailer);
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_beats", i), 32'(beat_n - base), 32'(v.exp_beats));
            for (int b = 0; b < v.exp_beats && b < (beat_n - base); b++) begin
                chk($sformatf("v%0d_data%0d", i, b), b_data[base + b], v.pay[b]);
                chk($sformatf("v%0d_side%0d", i, b), 32'(b_side[base + b]),
                    32'({(b == 0), (b == v.exp_beats - 1),
                         (b == v.exp_beats - 1) && v.exp_err, v.id}));
            end
            chk($sformatf("v%0d_frame_cnt", i), 32'(frame_cnt), 32'(v.exp_frames));
            chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(v.exp_errs));
            chk($sformatf("v%0d_drop_cnt", i), 32'(drop_cnt), 32'(v.exp_drops));
        end

        // Backpressure: 8-word frame (maximum length) with ready toggling
        base = beat_n;
        x    = 32'd0;
        push(32'hA577_0008);
        for (int p = 0; p < 8; p++) begin
            w = 32'hC0DE_0000 | 32'(p * 3 + 1);
            x = x ^ w;
            push(w);
        end
        push(x);
        for (int c = 0; c < 300 && (beat_n - base) < 8; c++) begin
            @(posedge clk);
            #1;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_idle("bp");
        chk("bp_beats", 32'(beat_n - base), 32'd8);
        for (int b = 0; b < 8 && b < (beat_n - base); b++) begin
            chk($sformatf("bp_data%0d", b), b_data[base + b], 32'hC0DE_0000 | 32'(b * 3 + 1));
            chk($sformatf("bp_side%0d", b), 32'(b_side[base + b]),
                32'({(b == 0), (b == 7), 1'b0, 8'h77}));
        end
        chk("bp_stalls_seen", 32'(stall_seen > 0), 32'd1);
        chk("bp_stall_stable", 32'(stall_viol), 32'd0);
        chk("bp_rd_full", 32'(full_viol), 32'd0);
        chk("bp_rd_empty", 32'(rd_empty_viol), 32'd0);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);

        // Reset in the middle of a 5-word frame
        base = beat_n;
        push(32'hA555_0005);
        for (int p = 0; p < 5; p++) push(32'h7000_0000 | 32'(p));
        push(32'h7000_0004);
        for (int c = 0; c < 100 && (beat_n - base) < 2; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cnts", {23'd0, frame_cnt, err_cnt, drop_cnt}, 32'd0);
        wr_cnt = rd_cnt;
        rst = 1'b0;
        base = beat_n;
        wait_idle("mr");
        chk("mr_no_more_beats", 32'(beat_n - base), 32'd0);

        base = beat_n;
        push(32'hA566_0002);
        push(32'hAAAA_0001);
        push(32'h5555_0002);
        push(32'hFFFF_0003);
        wait_idle("clean");
        chk("clean_beats", 32'(beat_n - base), 32'd2);
        chk("clean_data0", b_data[base], 32'hAAAA_0001);
        chk("clean_data1", b_data[base + 1], 32'h5555_0002);
        chk("clean_side1", 32'(b_side[base + 1]), 32'({1'b0, 1'b1, 1'b0, 8'h66}));
        chk("clean_cnts", {23'd0, frame_cnt, err_cnt, drop_cnt}, {23'd0, 3'd1, 3'd0, 3'd0});

        // Saturation: nine bad-checksum frames drive both counters to all-ones
        base = beat_n;
        for (int f = 0; f < 9; f++) begin
            push(32'hA5F0_0001);
            push(32'h0BAD_0000 | 32'(f));
            push(~(32'h0BAD_0000 | 32'(f)));
        end
        wait_idle("sat");
        chk("sat_beats", 32'(beat_n - base), 32'd9);
        chk("sat_last_side", 32'(b_side[base + 8]), 32'({1'b1, 1'b1, 1'b1, 8'hF0}));
        chk("sat_err_cnt", 32'(err_cnt), 32'd7);
        chk("sat_frame_cnt", 32'(frame_cnt), 32'd7);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_unpacker.md
Name: frame_unpacker

Overview:
- Read-side counterpart of the frame formatter: drains formatted 32-bit frame words from the formatter FIFO read port and reconstructs frames as a valid/ready stream with SOP/EOP/error sideband.
- Sits between the FIFO read port (fifo_rd_en / fifo_rd_data / fifo_empty) and the downstream consumer.
- Validates the header marker, length and XOR checksum trailer, and maintains frame, error and drop counters.

Parameters:
- MAX_LEN, 256, maximum legal payload length in words (1..65535).
- SYNC_MARK, 8'hA5, required header marker in bits [31:24].
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  FIFO read strobe; data is returned on fifo_rd_data exactly 1 cycle later.
- fifo_rd_data  in  32  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  payload word.
- out_sop  out  1  first payload word of a frame.
- out_eop  out  1  last payload word of a frame.
- out_err  out  1  checksum mismatch; meaningful only on the EOP beat.
- out_frame_id  out  8  header id; constant for the whole frame.
- frame_cnt  out  CNT_W  count of frames delivered.
- err_cnt  out  CNT_W  count of checksum errors plus length errors.
- drop_cnt  out  CNT_W  count of words discarded while hunting for a header.
- busy  out  1  high whenever state is not HUNT.

Behaviour:
- Frame format: header word = {mark[31:24], id[23:16], len[15:0]}, then len payload words, then one trailer word equal to the XOR of all payload words.
- Reset: all outputs 0, state HUNT, skid buffer and in-flight flag cleared. Read data returning in the cycle after reset is ignored.
- Input skid (2 entries):
  - fifo_rd_en = !fifo_empty && (occupancy + inflight) < 2.
  - The returned word is written into the skid 1 cycle after the read.
  - No read is issued while fifo_empty; no overflow is possible.
- Output register: out_* change only when out_valid==0 or out_ready==1. Data and sideband stay stable while stalled.
- State machine (states HUNT, PAYLOAD, TRAILER), one head word consumed per cycle at most:
  - HUNT: consume the head word unconditionally.
    - If mark==SYNC_MARK and 1<=len<=MAX_LEN: latch id, load remaining=len, clear the XOR accumulator, go to PAYLOAD.
    - If the mark is bad: drop_cnt++, stay in HUNT.
    - If the mark is good but len==0 or len>MAX_LEN: err_cnt++, stay in HUNT, no output.
  - PAYLOAD, remaining>1: consume only when the output slot is free. Emit the word with sop = first word, eop=0; XOR-accumulate; remaining--.
  - PAYLOAD, remaining==1: consume into the hold register with no output; XOR-accumulate; go to TRAILER.
  - TRAILER: consume when the output slot is free. Emit the held word with eop=1, sop=1 if len==1, err=(trailer != accumulator).
    - frame_cnt++; err_cnt++ if err; return to HUNT.
- Minimum latency: FIFO word to out_valid is 2 cycles (read + skid). The last payload word appears only after its trailer is consumed.
- Throughput: 1 payload word per cycle with out_ready held high, after the initial fill.
- Counters saturate at all-ones and never wrap.
- If the FIFO runs empty mid-frame, the parser waits in its current state indefinitely; there is no timeout.
- Reset mid-frame: the partial frame is abandoned, no EOP is emitted, and counters return to 0.

Decomposition:
- Shared package frame_pkg:
  - state enum {HUNT, PAYLOAD, TRAILER};
  - header field positions (MARK_HI/LO, ID_HI/LO, LEN_HI/LO);
  - SYNC_MARK default;
  - a header struct typedef.
  - The formatter will reuse this package.
- One sub-module, frame_unpacker_skid: a 2-entry buffer with an in-flight read tracker that owns fifo_rd_en and presents head valid/data/pop to the parser.

Test Plan:
- Single frame: FIFO holds {A5_07_0003}, 11, 22, 33, trailer 00 (11^22^33) → beats 11(sop), 22, 33(eop, err=0), frame_id=07, frame_cnt=1, err_cnt=0.
- len=1: {A5_01_0001}, DEAD_BEEF, DEAD_BEEF → one beat with sop=eop=1, err=0. Corrupt trailer to 0 → err=1, err_cnt=1.
- Resync: 3 garbage words (mark 00) then a valid 2-word frame → drop_cnt=3, frame delivered intact; header len=0 → err_cnt+1, no beats.
- Backpressure: 8-word frame with out_ready toggled 1/0 each cycle → no beat lost or duplicated, out_data stable while stalled, fifo_rd_en never asserted with skid full.
- Reset mid-frame: assert rst after the 2nd of 5 payload words → out_valid=0 next cycle, busy=0, all counters 0; the next clean frame is received correctly.
- Saturation: force err_cnt to FFFE, send 3 bad-checksum frames → err_cnt ends at FFFF.
